addsub_pipe: RTL
================

Name: addsub_pipe

Overview:
- Parametrised, pipelined two's-complement adder/subtractor; next generation of the team's ripple add/sub block.
- Splits the WIDTH-bit carry chain into SEG-bit segments, one segment per register stage.
- Adds a valid/ready stream handshake, explicit op/carry-in control, optional signed saturation and a full flag set (carry, overflow, zero, negative).
- Sits in the ALU datapath between operand registers and writeback.

Parameters:
- WIDTH, 16, operand/result width in bits; must be a multiple of SEG.
- SEG, 4, bits resolved per pipeline stage; STAGES = WIDTH/SEG (>= 1).

Ports:
- clk  input  1  rising-edge clock
- rst  input  1  synchronous, active-high reset
- in_valid  input  1  operand beat valid
- in_ready  output  1  block can accept a beat this cycle
- in_a  input  WIDTH  operand A
- in_b  input  WIDTH  operand B
- in_op  input  1  0 = add, 1 = subtract (B inverted)
- in_cin  input  1  carry-in into bit 0
- in_sat  input  1  1 = clamp result on signed overflow
- out_valid  output  1  result beat valid
- out_ready  input  1  downstream accepts result
- out_result  output  WIDTH  result
- out_cout  output  1  raw carry-out of the MSB
- out_ovf  output  1  signed overflow: carry into MSB XOR carry out of MSB
- out_zero  output  1  out_result == 0
- out_neg  output  1  out_result[WIDTH-1]

Behaviour:
- One clock, clk. Reset rst is synchronous and active-high.
- Arithmetic:
  - Effective B = in_b XOR {WIDTH{in_op}}.
  - Raw sum = in_a + effB + in_cin, computed mod 2^WIDTH.
  - Subtract is in_op=1 with in_cin=1. in_op=1 with in_cin=0 gives A + ~B, i.e. A - B - 1 (borrow chain).
- Pipeline:
  - STAGES register stages. Stage k (k = 0..STAGES-1) adds bits [k*SEG +: SEG] using the carry registered by stage k-1; stage 0 uses in_cin.
  - Remaining operand bits, op, sat and a valid bit travel with each stage.
  - The last stage register is the output register. It also holds the flags and the saturated result, computed in the same edge as the final segment.
- Latency:
  - A beat accepted at edge n is presented on out_* immediately after edge n+STAGES-1.
  - WIDTH=16, SEG=4: accept at edge 0, output valid after edge 3.
- Handshake:
  - adv = !out_valid | out_ready; in_ready = adv. in_ready is combinational from out_ready by design.
  - When adv=1, every stage shifts one place and stage 0 captures the input beat, or a bubble when in_valid=0.
  - When adv=0, every stage holds; out_* stay stable while out_valid=1 and out_ready=0.
  - Throughput is 1 beat per cycle. Order is preserved. No beat is dropped or duplicated.
  - Bubbles never raise out_valid.
- Saturation (in_sat=1 and ovf=1):
  - If A's sign after effB inversion gives positive overflow (raw MSB=1), out_result = 0 followed by WIDTH-1 ones, i.e. max positive.
  - Otherwise out_result = 1 followed by WIDTH-1 zeros, i.e. min negative.
  - out_ovf remains 1. out_cout reports the raw carry.
  - out_zero and out_neg are taken from the final (post-saturation) result.
- Reset:
  - All stage valid bits = 0, out_valid = 0, out_result = 0, all flags = 0.
  - in_ready = 1 during the cycle after reset.
  - rst mid-operation discards all in-flight beats; nothing they carried is ever emitted.
  - An input presented in the same cycle as rst is not accepted.
- Simultaneous events: out_valid & out_ready together with in_valid in one cycle: the output retires and the new beat enters on the same edge.

Test Plan:
- Defaults, add, sat=0: A=0x7FFF, B=0x0001, op=0, cin=0 -> result 0x8000, ovf=1, cout=0, neg=1, zero=0; out_valid rises after the 4th edge from acceptance. Same beat with sat=1 -> result 0x7FFF, ovf=1, neg=0.
- Subtract: A=0x0005, B=0x0005, op=1, cin=1 -> 0x0000, zero=1, cout=1, ovf=0. A=0x8000, B=0x0001, op=1, cin=1, sat=1 -> raw 0x7FFF clamps to 0x8000, ovf=1, neg=1.
- Cross-segment carry: A=0x0FFF, B=0x0001 -> 0x1000, cout=0. A=0xFFFF, B=0x0001 -> 0x0000, cout=1, zero=1, ovf=0.
- Streaming/backpressure: 32 random beats back-to-back while out_ready toggles pseudo-randomly -> results match the reference model in order, none lost or duplicated, out_* stable while stalled.
- Reset mid-flight: 3 beats in flight, rst high for 1 cycle -> out_valid=0 from the next cycle, none of the 3 results appear, and the next accepted beat completes with normal latency.
- Parameter sweep: WIDTH=8/SEG=8 (STAGES=1, one-cycle latency) and WIDTH=32/SEG=4 (STAGES=8) -> exhaustive 8-bit checks and random 32-bit checks pass with latency = STAGES.

Source files
------------

// File: rtl/addsub_pipe.sv
`default_nettype none
// ============================================================================
//  Module  : addsub_pipe
//  Brief   : Segmented, pipelined two's-complement add/sub with stream
//            handshake, optional signed saturation and carry/ovf/zero/neg flags.
//  Rev     : 1.0
// ============================================================================
module addsub_pipe #(
   parameter int WIDTH = 16,
   parameter int SEG   = 4
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_a,
   input  logic [WIDTH-1:0] in_b,
   input  logic             in_op,
   input  logic             in_cin,
   input  logic             in_sat,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_result,
   output logic             out_cout,
   output logic             out_ovf,
   output logic             out_zero,
   output logic             out_neg
);

   // WIDTH must be a whole multiple of SEG.
   localparam int c_STAGES = WIDTH / SEG;
   localparam int c_LAST   = c_STAGES - 1;
   localparam int c_NMID   = (c_STAGES > 1) ? c_STAGES - 1 : 1;

   localparam logic [WIDTH-1:0] c_MAXPOS = {1'b0, {(WIDTH-1){1'b1}}};
   localparam logic [WIDTH-1:0] c_MINNEG = {1'b1, {(WIDTH-1){1'b0}}};

   // Stage inputs (from the ports for stage 0, from the previous register otherwise)
   logic [WIDTH-1:0] w_a   [c_STAGES];
   logic [WIDTH-1:0] w_b   [c_STAGES];
   logic [WIDTH-1:0] w_s   [c_STAGES];
   logic             w_c   [c_STAGES];
   logic             w_sat [c_STAGES];
   logic             w_v   [c_STAGES];
   logic [SEG:0]     w_seg [c_STAGES];
   logic [WIDTH-1:0] w_sn  [c_STAGES];

   logic [WIDTH-1:0] r_a   [c_NMID];
   logic [WIDTH-1:0] r_b   [c_NMID];
   logic [WIDTH-1:0] r_s   [c_NMID];
   logic             r_c   [c_NMID];
   logic             r_sat [c_NMID];
   logic             r_v   [c_NMID];

   logic             r_out_valid;
   logic [WIDTH-1:0] r_out_result;
   logic             r_out_cout;
   logic             r_out_ovf;
   logic             r_out_zero;
   logic             r_out_neg;

   logic             w_adv;
   logic [WIDTH-1:0] w_raw;
   logic             w_cout;
   logic             w_ovf;
   logic [WIDTH-1:0] w_res;

   assign w_adv    = !r_out_valid | out_ready;
   assign in_ready = w_adv;

   generate
      for (genvar k = 0; k < c_STAGES; k++) begin : g_stage
         if (k == 0) begin : g_first
            assign w_a[k]   = in_a;
            assign w_b[k]   = in_b ^ {WIDTH{in_op}};
            assign w_s[k]   = '0;
            assign w_c[k]   = in_cin;
            assign w_sat[k] = in_sat;
            assign w_v[k]   = in_valid;
         end else begin : g_next
            assign w_a[k]   = r_a[k-1];
            assign w_b[k]   = r_b[k-1];
            assign w_s[k]   = r_s[k-1];
            assign w_c[k]   = r_c[k-1];
            assign w_sat[k] = r_sat[k-1];
            assign w_v[k]   = r_v[k-1];
         end

         assign w_seg[k] = {1'b0, w_a[k][k*SEG +: SEG]}
                         + {1'b0, w_b[k][k*SEG +: SEG]}
                         + {{SEG{1'b0}}, w_c[k]};
         // Bits above this segment are still zero, so OR merges the new slice.
         assign w_sn[k]  = w_s[k] | (WIDTH'(w_seg[k][SEG-1:0]) << (k*SEG));
      end
   endgenerate

   assign w_raw  = w_sn[c_LAST];
   assign w_cout = w_seg[c_LAST][SEG];
   // Carry into the MSB is a^b^sum at that bit; overflow is it XOR carry-out.
   assign w_ovf  = w_a[c_LAST][WIDTH-1] ^ w_b[c_LAST][WIDTH-1] ^ w_raw[WIDTH-1] ^ w_cout;

   always_comb begin
      w_res = w_raw;
      if (w_sat[c_LAST] && w_ovf) begin
         w_res = w_raw[WIDTH-1] ? c_MAXPOS : c_MINNEG;
      end
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         for (int k = 0; k < c_NMID; k++) begin
            r_v[k]   <= 1'b0;
            r_a[k]   <= '0;
            r_b[k]   <= '0;
            r_s[k]   <= '0;
            r_c[k]   <= 1'b0;
            r_sat[k] <= 1'b0;
         end
         r_out_valid  <= 1'b0;
         r_out_result <= '0;
         r_out_cout   <= 1'b0;
         r_out_ovf    <= 1'b0;
         r_out_zero   <= 1'b0;
         r_out_neg    <= 1'b0;
      end else if (w_adv) begin
         for (int k = 0; k < c_NMID; k++) begin
            r_v[k]   <= w_v[k];
            r_a[k]   <= w_a[k];
            r_b[k]   <= w_b[k];
            r_s[k]   <= w_sn[k];
            r_c[k]   <= w_seg[k][SEG];
            r_sat[k] <= w_sat[k];
         end
         r_out_valid  <= w_v[c_LAST];
         r_out_result <= w_res;
         r_out_cout   <= w_cout;
         r_out_ovf    <= w_ovf;
         r_out_zero   <= (w_res == '0);
         r_out_neg    <= w_res[WIDTH-1];
      end
   end

   assign out_valid  = r_out_valid;
   assign out_result = r_out_result;
   assign out_cout   = r_out_cout;
   assign out_ovf    = r_out_ovf;
   assign out_zero   = r_out_zero;
   assign out_neg    = r_out_neg;

endmodule
`default_nettype wire
